dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between the CPU MEM stage and an external host/debug port, used for program data preload and result readback.
- Sits between the EX/MEM register outputs and the data memory. Its stall output is ORed into the pipeline stall.
- CPU has default priority. A starvation counter guarantees the host a slot within STARVE_LIMIT+1 cycles.

Parameters:
- AW, 8, address width
- DW, 8, data width
- STARVE_LIMIT, 4, consecutive host-blocked cycles before the host is forced in (1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_mem_read  in  1  CPU MEM-stage load request
- cpu_mem_write  in  1  CPU MEM-stage store request
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU store data
- cpu_rdata  out  DW  CPU load data (combinational pass-through of mem_rdata)
- cpu_stall  out  1  CPU must hold the MEM stage this cycle
- host_req  in  1  host transfer request, level held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DW  registered host read data, valid when host_ack=1 and held until the next host read
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory (memory writes on clk edge)
- mem_addr  out  AW  to data memory
- mem_wdata  out  DW  to data memory
- mem_rdata  in  DW  from data memory (combinational read)

Behaviour:
- cpu_req = cpu_mem_read | cpu_mem_write.
- FSM states: CPU_OWN, HOST_XFER, HOST_DONE. Reset state is CPU_OWN.
- CPU_OWN:
  - Memory ports are driven by the CPU. If both CPU strobes are high, write wins and mem_read=0.
  - Transition to HOST_XFER when host_req & (!cpu_req | starve_cnt==STARVE_LIMIT).
  - On that edge, latch host_we, host_addr and host_wdata into internal registers.
- HOST_XFER:
  - Memory ports are driven from the latched host fields for exactly one cycle: mem_write=we_q, mem_read=!we_q.
  - cpu_stall = cpu_req (combinational). cpu_stall=0 when the CPU is not requesting.
  - At the edge, host_rdata <= mem_rdata if !we_q; otherwise host_rdata is unchanged.
  - Always go to HOST_DONE.
- HOST_DONE:
  - host_ack=1. Memory ports are driven by the CPU and cpu_stall=0.
  - host_req is ignored this cycle; the host deasserts it or holds it for a new transfer.
  - Always go to CPU_OWN.
- Back-to-back host transfers are therefore spaced at least 3 cycles apart, and the CPU always gets the HOST_DONE cycle.
- starve_cnt (4 bits):
  - Cleared on reset and on entry to HOST_XFER.
  - Incremented (saturating at STARVE_LIMIT) in each CPU_OWN cycle with host_req & cpu_req.
  - Holds in all other cases.
- Outputs registered on clk: host_ack (derived from state), host_rdata, state, starve_cnt, latched host fields.
- Combinational outputs: cpu_stall, cpu_rdata, mem_* muxes.
- Reset values:
  - state=CPU_OWN, starve_cnt=0, host_ack=0, host_rdata=0, latched fields=0.
  - Hence cpu_stall=0 and mem_* follow the CPU inputs.
- Reset mid-transfer (in HOST_XFER or HOST_DONE):
  - Return to CPU_OWN on the reset edge.
  - No host_ack is issued. A host write in progress whose edge coincides with reset is still committed by memory, because memory is not reset. The host must retry.
- cpu_rdata = mem_rdata at all times. It is valid only when the CPU owns the port.

Test Plan:
- Idle CPU, host read addr 0x10 (mem[0x10]=0xA5): host_req rises at cycle 0 -> HOST_XFER at cycle 1 with mem_read=1, mem_addr=0x10, cpu_stall=0 -> host_ack=1 and host_rdata=0xA5 at cycle 2 -> CPU_OWN at cycle 3.
- Host write 0x3C to 0x20 while CPU idle -> mem_write=1 for exactly 1 cycle. A later CPU load of 0x20 returns cpu_rdata=0x3C and host_rdata is unchanged.
- CPU load every cycle, host_req held, STARVE_LIMIT=4 -> starve_cnt reaches 4 after 4 cycles, HOST_XFER occurs on cycle 5 with cpu_stall=1 for 1 cycle, host_ack on cycle 6 with cpu_stall=0.
- CPU asserts cpu_mem_read and cpu_mem_write together, addr 0x05, wdata 0x77 -> mem_write=1, mem_read=0, mem[0x05]=0x77.
- Reset asserted during HOST_XFER of a read -> next cycle state=CPU_OWN, host_ack never pulses, host_rdata=0, starve_cnt=0, cpu_stall=0.
- host_req held continuously with CPU idle -> transfers complete every 3 cycles, host_ack pulses at cycles 2, 5, 8.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU MEM-stage, host/debug and data-memory signals around the data memory arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          cpu_mem_read;
  logic          cpu_mem_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the host/debug port.
// The CPU has priority. A starvation counter forces the host in after STARVE_LIMIT blocked cycles.
module dmem_arbiter #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    HOST_XFER = 2'd1,
    HOST_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic cpu_req;
  logic host_slot;
  logic grant;

  assign cpu_req   = bus.cpu_mem_read | bus.cpu_mem_write;
  assign host_slot = (state == HOST_XFER);
  assign grant     = bus.host_req & (~cpu_req | (starve_cnt == LIMIT));

  // FSM, starvation counter, latched host command and host-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CPU_OWN;
      starve_cnt     <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.host_ack   <= 1'b0;
      bus.host_rdata <= '0;
    end else begin
      case (state)
        CPU_OWN: begin
          bus.host_ack <= 1'b0;
          if (grant) begin
            state      <= HOST_XFER;
            starve_cnt <= '0;
            we_q       <= bus.host_we;
            addr_q     <= bus.host_addr;
            wdata_q    <= bus.host_wdata;
          end else if (bus.host_req && cpu_req && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + CW'(1);
          end
        end
        HOST_XFER: begin
          if (!we_q) bus.host_rdata <= bus.mem_rdata;
          bus.host_ack <= 1'b1;
          state        <= HOST_DONE;
        end
        HOST_DONE: begin
          bus.host_ack <= 1'b0;
          state        <= CPU_OWN;
        end
        default: begin
          bus.host_ack <= 1'b0;
          state        <= CPU_OWN;
        end
      endcase
    end
  end

  // Memory port mux: host only during its single transfer cycle; write wins over read for the CPU
  assign bus.mem_write = host_slot ? we_q    : bus.cpu_mem_write;
  assign bus.mem_read  = host_slot ? ~we_q   : (bus.cpu_mem_read & ~bus.cpu_mem_write);
  assign bus.mem_addr  = host_slot ? addr_q  : bus.cpu_addr;
  assign bus.mem_wdata = host_slot ? wdata_q : bus.cpu_wdata;

  assign bus.cpu_stall = host_slot & cpu_req;
  assign bus.cpu_rdata = bus.mem_rdata;
endmodule
